lsu_split_unit: RTL and testbench

- Load/store unit between the MEM pipeline stage and the word-addressed data memory.
- Converts byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory chip-select, write, mask, word-address and lane-aligned write-data signals.
- Extracts and sign/zero-extends load data from memory read words.
- Accesses that cross a word boundary are split into two sequential memory accesses; the pipeline is stalled for one extra cycle while this happens.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/lsu_split_unit.sv | 153 +++++++++++++++
 tb/tb_lsu_split_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_size_e  : access size decoded from funct3[1:0]
//   lsu_state_e : split-access state
//   F3_*        : RV32I load/store funct3 encodings
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_B,
    LSU_H,
    LSU_W
  } lsu_size_e;

  typedef enum logic {
    LSU_IDLE,
    LSU_SECOND
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Stores only use 000/001/010, which are a subset of the load encodings.
  function automatic logic f3_valid(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return LSU_B;
      2'b01:   return LSU_H;
      default: return LSU_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
// Ports:
//   size      : access size
//   off       : byte offset within the first word
//   zext      : 1 = zero-extend load result, 0 = sign-extend
//   wdata     : right-justified store data
//   rdata64   : {second word, first word} of read data
//   mask8     : byte-lane mask across both words ([3:0] first, [7:4] second)
//   wdata64   : lane-aligned store data ([31:0] first, [63:32] second)
//   load_data : extracted and extended load result
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  output logic [7:0]  mask8,
  output logic [63:0] wdata64,
  output logic [31:0] load_data
);

  logic [3:0]  base_mask;
  logic [4:0]  sh_amt;
  logic [63:0] rshift;
  logic [31:0] lane;
  logic        unused_hi;

  assign sh_amt = {off, 3'b000};

  always_comb begin
    base_mask = 4'b0000;
    case (size)
      LSU_B:   base_mask = 4'b0001;
      LSU_H:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  assign mask8   = {4'b0000, base_mask} << off;
  // Duplicating the word makes the wrap into the second access fall out of one shift.
  assign wdata64 = {wdata, wdata} << sh_amt;

  assign rshift    = rdata64 >> sh_amt;
  assign lane      = rshift[31:0];
  assign unused_hi = ^rshift[63:32];

  always_comb begin
    load_data = lane;
    case (size)
      LSU_B:   load_data = zext ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      LSU_H:   load_data = zext ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_split_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Byte-addressed RV32I loads/stores become chip-select/write/mask/word-address
// memory controls; word-crossing accesses are split into two accesses with a
// one-cycle stall. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of splitting them.
// Ports:
//   clk, rst                  : clock (posedge), async active-low reset
//   req_valid/store/funct3    : MEM-stage request control
//   req_addr, req_wdata       : byte address, right-justified store data
//   flush                     : kill the in-flight request
//   stall                     : hold the MEM stage
//   load_valid, load_data     : extended load result
//   misalign_exc              : misaligned-access exception (trap build only)
//   mem_cs (low), mem_wr (0=write), mem_mask, mem_addr, mem_wdata : memory side
//   mem_rdata                 : asynchronous memory read data
module lsu_split_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              misalign_exc,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [31:0]       lo_buf_q, lo_buf_d;

  lsu_size_e         size;
  logic [1:0]        off;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        mask8;
  logic [63:0]       wdata64;
  logic [63:0]       rdata64;
  logic [31:0]       ext_data;
  logic              split;
  logic              go;
  logic              misaligned;
  logic              unused_addr;

  assign size        = f3_size(req_funct3);
  assign off         = req_addr[1:0];
  assign word_addr   = req_addr[ADDR_W+1:2];
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign split       = |mask8[7:4];
  assign misaligned  = ((size == LSU_H) && off[0]) || ((size == LSU_W) && (off != 2'b00));

  // rst is folded in so every output sits at its idle value while reset is held.
  assign go = rst && req_valid && f3_valid(req_funct3) && !flush;

  // In SECOND the first word comes from lo_buf; otherwise only the low word matters.
  assign rdata64 = (state_q == LSU_SECOND) ? {mem_rdata, lo_buf_q} : {32'h0, mem_rdata};

  lsu_lane_align u_align (
    .size      (size),
    .off       (off),
    .zext      (req_funct3[2]),
    .wdata     (req_wdata),
    .rdata64   (rdata64),
    .mask8     (mask8),
    .wdata64   (wdata64),
    .load_data (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    lo_buf_d     = lo_buf_q;
    stall        = 1'b0;
    load_valid   = 1'b0;
    misalign_exc = 1'b0;
    mem_cs       = 1'b1;
    mem_wr       = 1'b1;
    mem_mask     = 4'b0000;
    mem_addr     = '0;
    mem_wdata    = 32'h0;

    case (state_q)
      LSU_IDLE: begin
        if (go) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            mem_cs     = 1'b0;
            mem_wr     = ~req_store;
            mem_addr   = word_addr;
            mem_mask   = mask8[3:0];
            mem_wdata  = wdata64[31:0];
            load_valid = ~req_store;
          end
`else
          mem_cs    = 1'b0;
          mem_wr    = ~req_store;
          mem_addr  = word_addr;
          mem_mask  = mask8[3:0];
          mem_wdata = wdata64[31:0];
          if (split) begin
            stall    = 1'b1;
            state_d  = LSU_SECOND;
            lo_buf_d = mem_rdata;
          end else begin
            load_valid = ~req_store;
          end
`endif
        end
      end
`ifndef LSU_MISALIGN_TRAP_EN
      LSU_SECOND: begin
        // Always leave after one cycle; a flush just drops the second access.
        state_d = LSU_IDLE;
        if (go) begin
          mem_cs     = 1'b0;
          mem_wr     = ~req_store;
          mem_addr   = word_addr + ADDR_W'(1);
          mem_mask   = mask8[7:4];
          mem_wdata  = wdata64[63:32];
          load_valid = ~req_store;
        end
      end
`endif
      default: state_d = LSU_IDLE;
    endcase

    load_data = load_valid ? ext_data : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LSU_IDLE;
      lo_buf_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      lo_buf_q <= lo_buf_d;
    end
  end

endmodule

// File: tb/tb_lsu_split_unit.sv
module tb_lsu_split_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign_exc;
  logic        mem_cs;
  logic        mem_wr;
  logic [3:0]  mem_mask;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  lsu_split_unit #(.ADDR_W(20), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign_exc (misalign_exc),
    .mem_cs       (mem_cs),
    .mem_wr       (mem_wr),
    .mem_mask     (mem_mask),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small memory model: low 8 word-address bits select a word; writes on negedge.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end else if (!mem_cs && !mem_wr) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[7:0]][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every load_valid pops one expected load result.
  always @(negedge clk) begin
    if (load_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_stray: got load_data %h with no load expected", load_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (load_data !== e) begin
          fails++;
          $display("FAIL sb_load: got %h expected %h", load_data, e);
        end
      end
    end
  end

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
    logic        exp_cs;
    logic        split;
    logic [19:0] a0;
    logic [3:0]  m0;
    logic [31:0] wd0;
    logic [19:0] a1;
    logic [3:0]  m1;
    logic [31:0] wd1;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs [12];

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic run_vec(input vec_t v);
    logic trap_exp;
    trap_exp = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap_exp = v.mis;
`endif
    drive(v.store, v.f3, v.addr, v.wdata);
    if (!trap_exp && !v.exp_cs && !v.store) exp_q.push_back(v.ld);
    #2;
    if (trap_exp) begin
      chk("trap_exc", {31'h0, misalign_exc}, 32'd1);
      chk("trap_cs", {31'h0, mem_cs}, 32'd1);
      chk("trap_stall", {31'h0, stall}, 32'd0);
      chk("trap_lv", {31'h0, load_valid}, 32'd0);
      @(posedge clk); #1;
    end else begin
      chk("c1_cs", {31'h0, mem_cs}, {31'h0, v.exp_cs});
      chk("c1_stall", {31'h0, stall}, {31'h0, v.split});
      chk("c1_exc", {31'h0, misalign_exc}, 32'd0);
      if (!v.exp_cs) begin
        chk("c1_addr", {12'h0, mem_addr}, {12'h0, v.a0});
        chk("c1_mask", {28'h0, mem_mask}, {28'h0, v.m0});
        chk("c1_wr", {31'h0, mem_wr}, v.store ? 32'd0 : 32'd1);
        if (v.store) chk("c1_wdata", mem_wdata, v.wd0);
      end else begin
        chk("c1_mask_idle", {28'h0, mem_mask}, 32'd0);
      end
      @(posedge clk); #1;
      if (v.split) begin
        #1;
        chk("c2_cs", {31'h0, mem_cs}, 32'd0);
        chk("c2_addr", {12'h0, mem_addr}, {12'h0, v.a1});
        chk("c2_mask", {28'h0, mem_mask}, {28'h0, v.m1});
        chk("c2_stall", {31'h0, stall}, 32'd0);
        if (v.store) chk("c2_wdata", mem_wdata, v.wd1);
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          st  f3      addr          wdata         mis exp_cs split a0        m0    wd0           a1        m1    wd1           ld
    vecs[0]  = '{1, 3'b010, 32'h00000100, 32'h12345678, 0,  0,     0,    20'h00040, 4'hF, 32'h12345678, 20'h0,    4'h0, 32'h0,        32'h0};
    vecs[1]  = '{0, 3'b010, 32'h00000100, 32'h0,        0,  0,     0,    20'h00040, 4'hF, 32'h0,        20'h0,    4'h0, 32'h0,        32'h12345678};
    vecs[2]  = '{1, 3'b000, 32'h00000103, 32'h000000AB, 0,  0,     0,    20'h00040, 4'h8, 32'hAB000000, 20'h0,    4'h0, 32'h0,        32'h0};
    vecs[3]  = '{0, 3'b000, 32'h00000103, 32'h0,        0,  0,     0,    20'h00040, 4'h8, 32'h0,        20'h0,    4'h0, 32'h0,        32'hFFFFFFAB};
    vecs[4]  = '{0, 3'b100, 32'h00000103, 32'h0,        0,  0,     0,    20'h00040, 4'h8, 32'h0,        20'h0,    4'h0, 32'h0,        32'h000000AB};
    vecs[5]  = '{0, 3'b101, 32'h00000102, 32'h0,        0,  0,     0,    20'h00040, 4'hC, 32'h0,        20'h0,    4'h0, 32'h0,        32'h0000AB34};
    vecs[6]  = '{1, 3'b010, 32'h00000102, 32'hDEADBEEF, 1,  0,     1,    20'h00040, 4'hC, 32'hBEEF0000, 20'h00041, 4'h3, 32'hBEEFDEAD, 32'h0};
    vecs[7]  = '{0, 3'b010, 32'h00000102, 32'h0,        1,  0,     1,    20'h00040, 4'hC, 32'h0,        20'h00041, 4'h3, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{0, 3'b001, 32'h00000101, 32'h0,        1,  0,     0,    20'h00040, 4'h6, 32'h0,        20'h0,    4'h0, 32'h0,        32'hFFFFEF56};
    vecs[9]  = '{1, 3'b001, 32'h003FFFFF, 32'h00008765, 1,  0,     1,    20'hFFFFF, 4'h8, 32'h65000000, 20'h00000, 4'h1, 32'h65000087, 32'h0};
    vecs[10] = '{0, 3'b001, 32'h003FFFFF, 32'h0,        1,  0,     1,    20'hFFFFF, 4'h8, 32'h0,        20'h00000, 4'h1, 32'h0,        32'hFFFF8765};
    vecs[11] = '{0, 3'b011, 32'h00000100, 32'h0,        0,  1,     0,    20'h0,     4'h0, 32'h0,        20'h0,    4'h0, 32'h0,        32'h0};

    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
    #2;
    chk("rst_cs", {31'h0, mem_cs}, 32'd1);
    chk("rst_wr", {31'h0, mem_wr}, 32'd1);
    chk("rst_mask", {28'h0, mem_mask}, 32'd0);
    chk("rst_addr", {12'h0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    chk("rst_lv", {31'h0, load_valid}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_exc", {31'h0, misalign_exc}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

`ifndef LSU_MISALIGN_TRAP_EN
    // Flush during the second half of a split load.
    drive(1'b0, 3'b010, 32'h00000102, 32'h0);
    #2 chk("fl_c1_stall", {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    chk("fl_cs", {31'h0, mem_cs}, 32'd1);
    chk("fl_lv", {31'h0, load_valid}, 32'd0);
    chk("fl_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("fl_idle_addr", {12'h0, mem_addr}, 32'h40);
    chk("fl_idle_stall", {31'h0, stall}, 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Reset asserted while in the second half of a split load.
    drive(1'b0, 3'b010, 32'h00000102, 32'h0);
    @(posedge clk); #1;
    chk("rs_c2_addr", {12'h0, mem_addr}, 32'h41);
    rst = 1'b0;
    #1;
    chk("rs_cs", {31'h0, mem_cs}, 32'd1);
    chk("rs_mask", {28'h0, mem_mask}, 32'd0);
    chk("rs_lv", {31'h0, load_valid}, 32'd0);
    chk("rs_stall", {31'h0, stall}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 3'b010, 32'h00000102, 32'h0);
    #1;
    chk("rs_idle_addr", {12'h0, mem_addr}, 32'h40);
    chk("rs_idle_stall", {31'h0, stall}, 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
`else
    // Misaligned word load traps with no memory access.
    drive(1'b0, 3'b010, 32'h00000101, 32'h0);
    #2;
    chk("tr_exc", {31'h0, misalign_exc}, 32'd1);
    chk("tr_cs", {31'h0, mem_cs}, 32'd1);
    chk("tr_stall", {31'h0, stall}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
